// File: rtl/masked_subbytes_seq.sv
// Byte-serial SubBytes sequencer that feeds a pipelined masked S-box and collects its results.
// Optional build macro: SUBBYTES_ZERO_IDLE_EN forces the S-box input to zero whenever no byte is issued.
module masked_subbytes_seq #(
  parameter int SHARES       = 2,
  parameter int NBYTES       = 16,
  parameter int SBOX_LATENCY = 4
) (
  input  logic                       ClkxCI,
  input  logic                       RstxRI,
  input  logic                       StartxSI,
  input  logic [8*NBYTES*SHARES-1:0] _StatexDI,
  output logic [8*NBYTES*SHARES-1:0] _StatexDO,
  output logic                       BusyxSO,
  output logic                       DonexSO,
  output logic [8*SHARES-1:0]        _SboxInxDO,
  input  logic [8*SHARES-1:0]        _SboxOutxDI,
  output logic                       RandEnxSO
);

  localparam int CntWidth = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {
    Idle,
    Feed,
    Drain,
    Done
  } state_t;

  state_t                       StatexDP, StatexDN;
  logic [CntWidth-1:0]          IssueCntxDP, CollectCntxDP;
  logic [SBOX_LATENCY-1:0]      ValidxDP;
  logic [8*NBYTES*SHARES-1:0]   StateInxDP, StateOutxDP;
  logic [8*SHARES-1:0]          SboxInxDP;
  logic [8*SHARES-1:0]          IssueBytexD;
  logic                         AcceptxS, IssuexS, LastIssuexS, CapturexS;

  // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    AcceptxS    = StartxSI && ((StatexDP == Idle) || (StatexDP == Done));
    IssuexS     = (StatexDP == Feed);
    LastIssuexS = IssuexS && (IssueCntxDP == CntWidth'(NBYTES - 1));
    CapturexS   = ValidxDP[SBOX_LATENCY-1];

    // Each share of the current byte is routed on its own; shares are never combined.
    IssueBytexD = '0;
    for (int i = 0; i < SHARES; i++) begin
      IssueBytexD[i*8 +: 8] = StateInxDP[(i*NBYTES + int'(IssueCntxDP))*8 +: 8];
    end
  end

  always_comb begin
    StatexDN = StatexDP;
    unique case (StatexDP)
      Idle:    if (StartxSI) StatexDN = Feed;
      Feed:    if (LastIssuexS) StatexDN = Drain;
      Drain:   if ((ValidxDP == '0) && (CollectCntxDP == CntWidth'(NBYTES))) StatexDN = Done;
      Done:    StatexDN = StartxSI ? Feed : Idle;
      default: StatexDN = Idle;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      // NOTE: the state registers are ordinary flops, so resetting them is cheap and
      // guarantees a zero result word after an aborted run.
      StatexDP      <= Idle;
      IssueCntxDP   <= '0;
      CollectCntxDP <= '0;
      ValidxDP      <= '0;
      StateInxDP    <= '0;
      StateOutxDP   <= '0;
      SboxInxDP     <= '0;
    end else begin
      StatexDP <= StatexDN;
      ValidxDP <= (ValidxDP << 1) | SBOX_LATENCY'(IssuexS);

      if (AcceptxS) begin
        StateInxDP  <= _StatexDI;
        IssueCntxDP <= '0;
      end else if (IssuexS) begin
        IssueCntxDP <= IssueCntxDP + 1'b1;
      end

      if (AcceptxS) begin
        CollectCntxDP <= '0;
      end else if (CapturexS) begin
        CollectCntxDP <= CollectCntxDP + 1'b1;
        for (int i = 0; i < SHARES; i++) begin
          StateOutxDP[(i*NBYTES + int'(CollectCntxDP))*8 +: 8] <= _SboxOutxDI[i*8 +: 8];
        end
      end

      if (IssuexS) begin
        SboxInxDP <= IssueBytexD;
      end
`ifdef SUBBYTES_ZERO_IDLE_EN
      else begin
        SboxInxDP <= '0;
      end
`endif
    end
  end

  assign _StatexDO  = StateOutxDP;
  assign _SboxInxDO = SboxInxDP;
  assign BusyxSO    = (StatexDP == Feed) || (StatexDP == Drain);
  assign DonexSO    = (StatexDP == Done);
  assign RandEnxSO  = (StatexDP == Feed) || (ValidxDP != '0);

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Self-checking bench for masked_subbytes_seq with a behavioural 2-share masked S-box model.
// Honours SUBBYTES_ZERO_IDLE_EN for the idle S-box input expectation.
module tb_masked_subbytes_seq;

  localparam int NB     = 16;
  localparam int SH     = 2;
  localparam int LAT    = 4;
  localparam int DONE_D = NB + LAT + 1;
  localparam int W      = 8 * NB * SH;

`ifdef SUBBYTES_ZERO_IDLE_EN
  localparam bit ZERO_IDLE = 1'b1;
`else
  localparam bit ZERO_IDLE = 1'b0;
`endif

  typedef logic [W-1:0]      vec_t;
  typedef logic [8*NB-1:0]   plain_t;
  typedef logic [8*SH-1:0]   pair_t;

  logic  clk = 1'b0;
  logic  RstxRI;
  logic  StartxSI;
  vec_t  StatexDI, StatexDO;
  logic  BusyxSO, DonexSO, RandEnxSO;
  pair_t SboxInxD, SboxOutxD;

  int nPass  = 0;
  int nTotal = 0;

  logic [7:0] sboxTab [256];
  plain_t     prevOut;
  pair_t      lastIssued;

  always #5 clk = ~clk;

  masked_subbytes_seq #(
    .SHARES(SH), .NBYTES(NB), .SBOX_LATENCY(LAT)
  ) dut (
    .ClkxCI(clk),
    .RstxRI(RstxRI),
    .StartxSI(StartxSI),
    ._StatexDI(StatexDI),
    ._StatexDO(StatexDO),
    .BusyxSO(BusyxSO),
    .DonexSO(DonexSO),
    ._SboxInxDO(SboxInxD),
    ._SboxOutxDI(SboxOutxD),
    .RandEnxSO(RandEnxSO)
  );

  // Masked S-box model: fresh mask per byte, result valid LAT edges after the issue edge.
  logic [7:0] maskNow;
  pair_t      sbPipe [LAT-1];
  always @(negedge clk) maskNow <= 8'($urandom);
  always @(posedge clk) begin
    sbPipe[0] <= {sboxTab[SboxInxD[7:0] ^ SboxInxD[15:8]] ^ maskNow, maskNow};
    for (int i = 1; i < LAT - 1; i++) sbPipe[i] <= sbPipe[i-1];
  end
  assign SboxOutxD = sbPipe[LAT-2];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxTab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic plain_t recomb(input vec_t v);
    plain_t r = '0;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < SH; i++) r[b*8 +: 8] = r[b*8 +: 8] ^ v[(i*NB + b)*8 +: 8];
    return r;
  endfunction

  function automatic plain_t sub_ref(input vec_t v);
    plain_t p = recomb(v);
    plain_t r = '0;
    for (int b = 0; b < NB; b++) r[b*8 +: 8] = sboxTab[p[b*8 +: 8]];
    return r;
  endfunction

  function automatic pair_t byte_shares(input vec_t v, input int k);
    pair_t r = '0;
    for (int i = 0; i < SH; i++) r[i*8 +: 8] = v[(i*NB + k)*8 +: 8];
    return r;
  endfunction

  function automatic vec_t rand_state();
    vec_t r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic start_idle(input vec_t v);
    @(negedge clk);
    StartxSI = 1'b1;
    StatexDI = v;
  endtask

  // Caller has driven StartxSI/StatexDI for the acceptance edge; cycle d is sampled d edges later.
  task automatic run_one(input vec_t stIn, input plain_t expNew, input bit holdStart, input int abortAt);
    plain_t expOut;
    pair_t  expIn;
    for (int d = 0; d <= DONE_D; d++) begin
      @(negedge clk);
      if (abortAt >= 0 && d == abortAt + 1) begin
        RstxRI = 1'b0;
        nTotal++; if (BusyxSO !== 1'b0) $display("FAIL abort_busy got %b want 0", BusyxSO); else nPass++;
        nTotal++; if (RandEnxSO !== 1'b0) $display("FAIL abort_randen got %b want 0", RandEnxSO); else nPass++;
        nTotal++; if (StatexDO !== '0) $display("FAIL abort_state got %h want 0", StatexDO); else nPass++;
        nTotal++; if (SboxInxD !== '0) $display("FAIL abort_sboxin got %h want 0", SboxInxD); else nPass++;
        prevOut    = '0;
        lastIssued = '0;
        for (int j = 0; j < DONE_D + 5; j++) begin
          @(negedge clk);
          nTotal++;
          if (DonexSO !== 1'b0 || BusyxSO !== 1'b0)
            $display("FAIL abort_quiet j=%0d done=%b busy=%b want 0/0", j, DonexSO, BusyxSO);
          else nPass++;
        end
        return;
      end

      nTotal++;
      if (BusyxSO !== 1'((d < DONE_D))) $display("FAIL busy d=%0d got %b want %b", d, BusyxSO, d < DONE_D);
      else nPass++;
      nTotal++;
      if (DonexSO !== 1'((d == DONE_D))) $display("FAIL done d=%0d got %b want %b", d, DonexSO, d == DONE_D);
      else nPass++;
      nTotal++;
      if (RandEnxSO !== 1'((d < NB + LAT))) $display("FAIL randen d=%0d got %b want %b", d, RandEnxSO, d < NB + LAT);
      else nPass++;

      if (d >= 1 && d <= NB) expIn = byte_shares(stIn, d - 1);
      else if (ZERO_IDLE)    expIn = '0;
      else if (d == 0)       expIn = lastIssued;
      else                   expIn = byte_shares(stIn, NB - 1);
      nTotal++;
      if (SboxInxD !== expIn) $display("FAIL sboxin d=%0d got %h want %h", d, SboxInxD, expIn);
      else nPass++;

      for (int k = 0; k < NB; k++)
        expOut[k*8 +: 8] = (d >= 1 + k + LAT) ? expNew[k*8 +: 8] : prevOut[k*8 +: 8];
      nTotal++;
      if (recomb(StatexDO) !== expOut) $display("FAIL result d=%0d got %h want %h", d, recomb(StatexDO), expOut);
      else nPass++;

      if (d == 0) begin
        StartxSI = holdStart;
        StatexDI = rand_state();
      end
      if (d == abortAt) RstxRI = 1'b1;
    end
    prevOut    = expNew;
    lastIssued = byte_shares(stIn, NB - 1);
  endtask

  task automatic test_reset();
    RstxRI   = 1'b1;
    StartxSI = 1'b0;
    StatexDI = rand_state();
    repeat (3) @(negedge clk);
    RstxRI = 1'b0;
    @(negedge clk);
    nTotal++;
    if ({BusyxSO, DonexSO, RandEnxSO} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {BusyxSO, DonexSO, RandEnxSO});
    else nPass++;
    nTotal++; if (StatexDO !== '0) $display("FAIL reset_state got %h want 0", StatexDO); else nPass++;
    nTotal++; if (SboxInxD !== '0) $display("FAIL reset_sboxin got %h want 0", SboxInxD); else nPass++;
    prevOut    = '0;
    lastIssued = '0;
  endtask

  task automatic test_zero_state();
    start_idle('0);
    run_one('0, {NB{8'h63}}, 1'b0, -1);
  endtask

  task automatic test_known_bytes();
    logic [7:0] ref_tab [NB] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                                 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
    vec_t   v;
    plain_t e;
    for (int b = 0; b < NB; b++) begin
      logic [7:0] m = 8'($urandom);
      v[b*8 +: 8]        = m;
      v[(NB + b)*8 +: 8] = 8'(b) ^ m;
      e[b*8 +: 8]        = ref_tab[b];
    end
    start_idle(v);
    run_one(v, e, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      vec_t v = rand_state();
      start_idle(v);
      run_one(v, sub_ref(v), 1'b0, -1);
    end
  endtask

  task automatic test_idle_input();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      nTotal++;
      if ({BusyxSO, DonexSO, RandEnxSO} !== 3'b000) $display("FAIL idle_ctrl j=%0d got %b want 000", j, {BusyxSO, DonexSO, RandEnxSO});
      else nPass++;
      nTotal++;
      if (SboxInxD !== (ZERO_IDLE ? pair_t'(0) : lastIssued))
        $display("FAIL idle_sboxin j=%0d got %h want %h", j, SboxInxD, ZERO_IDLE ? pair_t'(0) : lastIssued);
      else nPass++;
      nTotal++;
      if (recomb(StatexDO) !== prevOut) $display("FAIL idle_result j=%0d got %h want %h", j, recomb(StatexDO), prevOut);
      else nPass++;
    end
  endtask

  task automatic test_start_while_busy();
    vec_t a = rand_state();
    vec_t b = rand_state();
    start_idle(a);
    run_one(a, sub_ref(a), 1'b1, -1);
    StatexDI = b;
    run_one(b, sub_ref(b), 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    vec_t a = rand_state();
    vec_t b = rand_state();
    start_idle(a);
    run_one(a, sub_ref(a), 1'b0, -1);
    StartxSI = 1'b1;
    StatexDI = b;
    run_one(b, sub_ref(b), 1'b0, -1);
  endtask

  task automatic test_reset_mid_run();
    vec_t a = rand_state();
    vec_t b = rand_state();
    start_idle(a);
    run_one(a, sub_ref(a), 1'b0, 8);
    start_idle(b);
    run_one(b, sub_ref(b), 1'b0, -1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    build_sbox();
    test_reset();
    test_idle_input();
    test_zero_state();
    test_known_bytes();
    test_random();
    test_idle_input();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_idle_input();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
